// File: rtl/intr_pkg.sv
// Shared definitions for the vectored interrupt controller: register map and FSM states.
package intr_pkg;

  // Register select codes for the intAddr port
  localparam logic [1:0] INTR_ADDR_MASK  = 2'd0;
  localparam logic [1:0] INTR_ADDR_MODE  = 2'd1;
  localparam logic [1:0] INTR_ADDR_PEND  = 2'd2;
  localparam logic [1:0] INTR_ADDR_INSVC = 2'd3;

  // Request handshake states: IDLE arbitrates, REQ holds a frozen vector for the CPU
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } intr_state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-set-bit priority encoder; index 0 is the highest priority.
module intr_prio_enc #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] index
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = W'(i);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl_n.sv
// Parametrised vectored interrupt controller: synchronised sources, per-source mask and
// edge/level mode, fixed priority with nested in-service tracking, and a register port.
module intr_ctrl_n #(
  parameter  int NUM_SRC = 4,
  parameter  int DATA_W  = 16,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               intWrite,
  input  logic [1:0]         intAddr,
  input  logic [DATA_W-1:0]  intDataIn,
  output logic [DATA_W-1:0]  intDataOut,
  input  logic               intAck,
  input  logic               intEoi,
  output logic               intr,
  output logic [SRC_W-1:0]   intVec
);

  import intr_pkg::*;

  logic [NUM_SRC-1:0] s1, s2, s3;
  logic [NUM_SRC-1:0] maskReg, modeReg, pendEdge, insvc;
  intr_state_e        state;

  logic [NUM_SRC-1:0] writeData, modeNext, edgeDet, pend, eligible, prioBelow;
  logic [NUM_SRC-1:0] vecOneHot, w1cClr, ackClr, eoiClr, pendEdgeNext, insvcNext;
  logic               eligValid, insvcValid, ackTake, withdraw;
  logic [SRC_W-1:0]   eligIdx, insvcIdx;

  generate
    if (DATA_W > NUM_SRC) begin : g_unused
      logic unusedDataBits;
      assign unusedDataBits = ^intDataIn[DATA_W-1:NUM_SRC];
    end
  endgenerate

  assign writeData = intDataIn[NUM_SRC-1:0];
  assign modeNext  = (intWrite && intAddr == INTR_ADDR_MODE) ? writeData : modeReg;
  assign edgeDet   = s2 & ~s3;

  // Level sources read the synchronised line directly; edge sources read the latch
  assign pend      = (modeReg & pendEdge) | (~modeReg & s2);

  intr_prio_enc #(.N(NUM_SRC), .W(SRC_W)) u_insvc_enc (
    .req   (insvc),
    .valid (insvcValid),
    .index (insvcIdx)
  );

  // Only sources strictly more urgent than the most urgent in-service one may interrupt
  assign prioBelow = insvcValid ? ((NUM_SRC'(1) << insvcIdx) - NUM_SRC'(1)) : '1;
  assign eligible  = pend & maskReg & prioBelow;

  intr_prio_enc #(.N(NUM_SRC), .W(SRC_W)) u_elig_enc (
    .req   (eligible),
    .valid (eligValid),
    .index (eligIdx)
  );

  assign vecOneHot = NUM_SRC'(1) << intVec;
  assign ackTake   = (state == REQ) && intAck;
  assign withdraw  = (state == REQ) && !intAck && ((eligible & vecOneHot) == '0);

  assign w1cClr = (intWrite && intAddr == INTR_ADDR_PEND) ? writeData : '0;
  assign ackClr = ackTake ? vecOneHot : '0;
  assign eoiClr = (intEoi && insvcValid) ? (NUM_SRC'(1) << insvcIdx) : '0;

  // A new edge beats any clear in the same cycle; leaving edge mode drops the latch
  assign pendEdgeNext = ((pendEdge & ~(w1cClr | ackClr)) | edgeDet) & modeNext;

  // EOI retires against the pre-ack in-service set, then the acked source is added
  assign insvcNext = (insvc & ~eoiClr) | ackClr;

  // Register read mux, unused upper bits read as zero
  always_comb begin
    intDataOut = '0;
    case (intAddr)
      INTR_ADDR_MASK:  intDataOut = DATA_W'(maskReg);
      INTR_ADDR_MODE:  intDataOut = DATA_W'(modeReg);
      INTR_ADDR_PEND:  intDataOut = DATA_W'(pend);
      default:         intDataOut = DATA_W'(insvc);
    endcase
  end

  // Two-flop synchroniser plus a delay flop for edge detection
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Software-visible configuration and status state
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      maskReg  <= '0;
      modeReg  <= '0;
      pendEdge <= '0;
      insvc    <= '0;
    end else begin
      if (intWrite && intAddr == INTR_ADDR_MASK) begin
        maskReg <= writeData;
      end
      modeReg  <= modeNext;
      pendEdge <= pendEdgeNext;
      insvc    <= insvcNext;
    end
  end

  // Request handshake: arbitrate in IDLE, hold the vector in REQ until ack or withdraw
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      intr   <= 1'b0;
      intVec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (eligValid) begin
            state  <= REQ;
            intVec <= eligIdx;
            intr   <= 1'b1;
          end
        end
        default: begin
          if (ackTake || withdraw) begin
            state <= IDLE;
            intr  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
